// File: rtl/divider.sv
`timescale 1ns/1ps
// Integer clock divider: O_CLK = I_CLK / DIV_N with 50% duty for even and odd ratios.
// Odd ratios stretch the rising-edge phase by half a cycle with a falling-edge register.
module divider #(
    parameter int DIV_N = 4
) (
    input  logic I_CLK,
    input  logic rst,
    output logic O_CLK
);

    localparam int W = (DIV_N < 2) ? 1 : $clog2(DIV_N);
    localparam logic [W-1:0] CNT_LAST = W'(DIV_N - 1);

    logic [W-1:0] cnt;
    logic         p;

    if (DIV_N < 2) begin : g_bad_ratio
        $error("divider: DIV_N must be at least 2");
    end

    always_ff @(posedge I_CLK or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    if (DIV_N % 2 == 0) begin : g_even
        localparam logic [W-1:0] HALF_LAST = W'(DIV_N / 2 - 1);

        always_ff @(posedge I_CLK or negedge rst) begin
            if (!rst) begin
                p <= 1'b0;
            end else if (cnt == HALF_LAST || cnt == CNT_LAST) begin
                p <= ~p;
            end
        end

        always_comb O_CLK = p;
    end else begin : g_odd
        localparam logic [W-1:0] SET_AT = W'((DIV_N - 1) / 2 - 1);
        localparam logic [W-1:0] CLR_AT = W'(DIV_N - 2);

        logic n;

        always_ff @(posedge I_CLK or negedge rst) begin
            if (!rst) begin
                p <= 1'b0;
            end else if (cnt == SET_AT) begin
                p <= 1'b1;
            end else if (cnt == CLR_AT) begin
                p <= 1'b0;
            end
        end

        // Half-cycle delayed copy of p; OR-ing it in adds the extra half period of high time.
        always_ff @(negedge I_CLK or negedge rst) begin
            if (!rst) begin
                n <= 1'b0;
            end else begin
                n <= p;
            end
        end

        always_comb O_CLK = p | n;
    end

endmodule

// File: tb/tb_divider.sv
`timescale 1ns/1ps
// Scoreboard bench for divider: expected O_CLK edge times/levels are queued per instance
// (ratios 4, 2, 3, 5) and popped by monitors on every O_CLK transition.
module tb_divider;

    typedef struct {
        longint t;
        logic   v;
    } ev_t;

    logic i_clk = 1'b0;
    logic rst   = 1'b1;
    logic o4, o2, o3, o5;

    ev_t q0[$];
    ev_t q1[$];
    ev_t q2[$];
    ev_t q3[$];

    int total = 0;
    int bad   = 0;
    bit armed = 1'b0;
    int ratio[4] = '{4, 2, 3, 5};

    divider #(.DIV_N(4)) u_div4 (.I_CLK(i_clk), .rst(rst), .O_CLK(o4));
    divider #(.DIV_N(2)) u_div2 (.I_CLK(i_clk), .rst(rst), .O_CLK(o2));
    divider #(.DIV_N(3)) u_div3 (.I_CLK(i_clk), .rst(rst), .O_CLK(o3));
    divider #(.DIV_N(5)) u_div5 (.I_CLK(i_clk), .rst(rst), .O_CLK(o5));

    // T = 60 ns: rising edges at 30, 90, 150, ...; falling edges 30 ns after each rise.
    always #30 i_clk = ~i_clk;

    task automatic push(input int idx, input longint t, input logic v);
        ev_t e;
        e.t = t;
        e.v = v;
        case (idx)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            default: q3.push_back(e);
        endcase
    endtask

    // Expected edges for ratio n, with edge 1 at time edge1, up to a reset assertion at t_stop.
    task automatic gen(input int idx, input int n, input longint edge1, input longint t_stop);
        logic   lvl;
        longint te;
        lvl = 1'b0;
        for (int k = 1; edge1 + 60 * longint'(k - 1) < t_stop; k++) begin
            te = edge1 + 60 * longint'(k - 1);
            if (n % 2 == 0) begin
                if (k % n == n / 2) begin push(idx, te, 1'b1); lvl = 1'b1; end
                if (k % n == 0)     begin push(idx, te, 1'b0); lvl = 1'b0; end
            end else begin
                if (k % n == (n - 1) / 2) begin push(idx, te, 1'b1); lvl = 1'b1; end
                if (k % n == n - 1 && te + 30 < t_stop) begin
                    push(idx, te + 30, 1'b0);
                    lvl = 1'b0;
                end
            end
        end
        if (lvl) push(idx, t_stop, 1'b0);
    endtask

    task automatic gen_all(input longint edge1, input longint t_stop);
        for (int i = 0; i < 4; i++) gen(i, ratio[i], edge1, t_stop);
    endtask

    task automatic on_edge(input int idx, input logic v);
        ev_t    e;
        int     sz;
        longint now;
        now = $time;
        case (idx)
            0: sz = q0.size();
            1: sz = q1.size();
            2: sz = q2.size();
            default: sz = q3.size();
        endcase
        total++;
        if (sz == 0) begin
            bad++;
            $display("FAIL edge_div%0d: O_CLK -> %0b at %0d ns, no edge required", ratio[idx], v, now);
        end else begin
            case (idx)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            if (e.t != now || e.v !== v) begin
                bad++;
                $display("FAIL edge_div%0d: O_CLK -> %0b at %0d ns, required -> %0b at %0d ns",
                         ratio[idx], v, now, e.v, e.t);
            end
        end
    endtask

    always @(o4) if (armed) on_edge(0, o4);
    always @(o2) if (armed) on_edge(1, o2);
    always @(o3) if (armed) on_edge(2, o3);
    always @(o5) if (armed) on_edge(3, o5);

    task automatic chk_low(input string tag);
        logic [3:0] got;
        got = {o5, o3, o2, o4};
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got[i] !== 1'b0) begin
                bad++;
                $display("FAIL %s_div%0d: O_CLK=%0b, required 0", tag, ratio[i], got[i]);
            end
        end
    endtask

    task automatic chk_empty();
        int sz;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: sz = q0.size();
                1: sz = q1.size();
                2: sz = q2.size();
                default: sz = q3.size();
            endcase
            total++;
            if (sz != 0) begin
                bad++;
                $display("FAIL missing_div%0d: %0d required edges never seen, required 0", ratio[i], sz);
            end
        end
    endtask

    initial begin
        // Phase A: reset 1..100 ns, edge 1 at 150 ns, async reset at 3820 ns (10 ns after edge 62).
        gen_all(150, 3820);
        #1 rst = 1'b0;
        #1 armed = 1'b1;
        #48 chk_low("in_reset");          // t = 50
        #45 chk_low("in_reset_edge");     // t = 95, after rising edge at 90
        #5  rst = 1'b1;                   // t = 100
        #3720 rst = 1'b0;                 // t = 3820, between I_CLK edges
        #5  chk_low("async_reset");       // t = 3825
        // Phase B: release at 3880, edge 1 at 3930, stop with reset at 5140.
        gen_all(3930, 5140);
        #50 chk_low("held_reset");        // t = 3875, after rising edge at 3870
        #5  rst = 1'b1;                   // t = 3880
        #1260 rst = 1'b0;                 // t = 5140
        #10 chk_empty();
        chk_low("final_reset");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider.md
# divider

Parameterised integer clock divider. It derives a slower clock `O_CLK` from the input clock `I_CLK` by an elaboration-time ratio `DIV_N`, with 50 % duty cycle for both even and odd ratios. It sits at the clock-generation front of the design, feeding slow logic such as display scanning and counters. It holds `O_CLK` low while reset is asserted.

## Interface
- `DIV_N`, default 4: division ratio, integer ≥ 2. Values < 2 must cause an elaboration error. `O_CLK` period = `DIV_N` × `I_CLK` period.
- `I_CLK`  input  1  input clock; all logic uses its rising edge, except the odd-ratio half-cycle stage, which uses its falling edge.
- `rst`  input  1  reset: one clock; reset is asynchronous and active-low. `rst`=0 clears all state immediately; `rst`=1 means run.
- `O_CLK`  output  1  divided clock.

## Operation
- Internal counter `cnt`, width `$clog2(DIV_N)`.
  - Increments on each `I_CLK` rising edge.
  - Wraps from `DIV_N-1` to 0.
- Phase register `p`, updated on the rising edge.
- Even `DIV_N`:
  - `p` toggles on the rising edge where `cnt == DIV_N/2-1` and where `cnt == DIV_N-1`.
  - `O_CLK = p`.
  - High time is `DIV_N/2` input cycles; low time is `DIV_N/2` input cycles.
- Odd `DIV_N`:
  - `p` sets on the rising edge where `cnt == (DIV_N-1)/2 - 1`. For `DIV_N`=3 this is `cnt==0`.
  - `p` clears on the rising edge where `cnt == DIV_N-2`. So `p` is high for `(DIV_N-1)/2` cycles.
  - Register `n` captures `p` on each `I_CLK` falling edge.
  - `O_CLK = p | n`.
  - High time is `(DIV_N-1)/2 + 0.5` input cycles; low time matches it exactly, giving 50 % duty.
- Reset asserted (`rst`=0):
  - `cnt`, `p` and `n` are asynchronously forced to 0, so `O_CLK` = 0 within the same delta.
  - The outputs stay there for the whole assertion.
- Reset released: counting starts at the first `I_CLK` rising edge with `rst`=1. Release is registered; no glitch on `O_CLK`.
- Reset mid-period: `O_CLK` drops to 0 immediately, even if high; the phase restarts from `cnt`=0 on release.
- `O_CLK` must come from registers, possibly OR-ed with a falling-edge register. No combinational path from `I_CLK` to `O_CLK`.

## Timing
- Edge k means the k-th `I_CLK` rising edge after `rst` goes high, counting from 1.
- First `O_CLK` rising edge:
  - Even `DIV_N`: edge `DIV_N/2`.
  - Odd `DIV_N`: edge `(DIV_N-1)/2`.
- Even `DIV_N`:
  - `O_CLK` falls at edge `DIV_N`.
  - The cycle then repeats every `DIV_N` edges.
- Odd `DIV_N`:
  - `O_CLK` falls on the `I_CLK` falling edge that follows edge `DIV_N-1`.
  - The cycle then repeats every `DIV_N` input periods.
- In steady state:
  - Period is exactly `DIV_N` × T(`I_CLK`).
  - Duty is exactly 50 %, assuming an `I_CLK` duty of 50 %.
- `O_CLK` latency relative to the causing edge is one register clock-to-Q delay. In simulation it is zero-delay.

## Test plan
- `DIV_N`=4, T(`I_CLK`)=60 ns, hold `rst`=0 for 100 ns then release:
  - `O_CLK`=0 throughout reset.
  - First rise at edge 2.
  - Thereafter period 240 ns, high 120 ns.
- `DIV_N`=2:
  - `O_CLK` toggles on every `I_CLK` rising edge; period 2T.
  - `O_CLK`=0 before edge 1.
- `DIV_N`=3, T=60 ns:
  - First rise at edge 1.
  - High 90 ns, low 90 ns, period 180 ns.
  - `O_CLK` falls on an `I_CLK` falling edge.
- `DIV_N`=5, T=60 ns: high 150 ns, low 150 ns, period 300 ns; check over 10 output periods.
- Assert `rst`=0 asynchronously (between `I_CLK` edges) while `O_CLK`=1:
  - `O_CLK` goes to 0 immediately, without waiting for an `I_CLK` edge.
  - After release, the first-rise timing matches the fresh-reset case.
- `DIV_N`=1: elaboration fails.
